regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: NREQ-way writeback arbiter with registered RF write port and pending-write scoreboard; define WB_FIXED_PRIORITY_EN for fixed priority instead of round-robin
`timescale 1ns/1ps
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wr_enable,
  output logic [4:0]           wr_addr,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  output logic [31:0]          pend_mask
);
  logic            take;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     set_vec;
  logic [31:0]     clr_vec;
`ifdef WB_FIXED_PRIORITY_EN
  // lowest valid index wins; no grant is offered while reset is held
  always_comb begin
    req_ready = '0;
    sel_addr = '0;
    sel_data = '0;
    take = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!take && req_valid[i] && rst_n) begin
        take = 1'b1;
        req_ready[i] = 1'b1;
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end
`else
  logic [1:0] last_grant;
  logic [1:0] win;
  // rotating search starting one past the last accepted requester
  always_comb begin
    int idx;
    idx = 0;
    req_ready = '0;
    sel_addr = '0;
    sel_data = '0;
    win = '0;
    take = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!take && req_valid[idx] && rst_n) begin
        take = 1'b1;
        win = 2'(idx);
        req_ready[idx] = 1'b1;
        sel_addr = req_addr[5*idx +: 5];
        sel_data = req_data[XLEN*idx +: XLEN];
      end
    end
  end
  // pointer moves only on an accepted handshake; reset gives index 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= 2'(NREQ - 1);
    else if (take) last_grant <= win;
  end
`endif
  assign set_vec = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
  assign clr_vec = take ? (32'd1 << sel_addr) : 32'd0;
  // register-file write port: one-cycle latency, writes to r0 are swallowed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_enable <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_enable <= take && sel_addr != 5'd0;
      if (take) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end
  // pending scoreboard: issue sets win over same-cycle writeback clears, r0 never pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_mask <= '0;
    else pend_mask <= ((pend_mask & ~clr_vec) | set_vec) & ~32'd1;
  end
endmodule
